// File: rtl/rw_apb_engine_if.sv
// ---------------------------------------------------------------------------
// rw_apb_engine_if
// Purpose : bundles the arbiter-side and APB-side signals of rw_apb_engine.
//           Signal names match the engine's documented port names.
// Modports:
//   master : engine view. It receives the grants, requester address/data and
//            APB slave responses. It drives done/r_data/r_valid/err and the
//            APB master outputs.
//   slave  : environment view (arbiter + APB peripheral), the mirror image.
// Parameters: ADDR_W (address width), DATA_W (data width).
// ---------------------------------------------------------------------------
interface rw_apb_engine_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // arbiter side
   logic              w_grant;
   logic              r_grant;
   logic [ADDR_W-1:0] w_addr;
   logic [DATA_W-1:0] w_data;
   logic [ADDR_W-1:0] r_addr;
   logic              done;
   logic [DATA_W-1:0] r_data;
   logic              r_valid;
   logic              err;
   // APB side
   logic [ADDR_W-1:0] paddr;
   logic              psel;
   logic              penable;
   logic              pwrite;
   logic [DATA_W-1:0] pwdata;
   logic [DATA_W-1:0] prdata;
   logic              pready;
   logic              pslverr;

   modport master (
      input  w_grant, r_grant, w_addr, w_data, r_addr,
      input  prdata, pready, pslverr,
      output done, r_data, r_valid, err,
      output paddr, psel, penable, pwrite, pwdata
   );

   modport slave (
      output w_grant, r_grant, w_addr, w_data, r_addr,
      output prdata, pready, pslverr,
      input  done, r_data, r_valid, err,
      input  paddr, psel, penable, pwrite, pwdata
   );
endinterface

// File: rtl/rw_apb_engine.sv
// ---------------------------------------------------------------------------
// rw_apb_engine
// Purpose : executes the single read or write the arbiter has granted as one
//           APB master transfer (SETUP -> ACCESS -> RESP). It then pulses
//           done for one cycle so the arbiter can release its grant.
// Ports   :
//   clk      - rising-edge clock
//   reset_n  - asynchronous active-low reset
//   bus      - rw_apb_engine_if.master:
//              in : w_grant, r_grant, w_addr, w_data, r_addr,
//                   prdata, pready, pslverr
//              out: done, r_data, r_valid, err,
//                   paddr, psel, penable, pwrite, pwdata
// Parameters: ADDR_W, DATA_W, TIMEOUT_CYCLES (used with RW_APB_TIMEOUT_EN)
// Optional  : `define RW_APB_TIMEOUT_EN aborts an ACCESS phase after
//             TIMEOUT_CYCLES cycles of pready low. The abort reports err=1
//             and leaves r_data unchanged.
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module rw_apb_engine #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic              clk,
   input logic              reset_n,
   rw_apb_engine_if.master  bus
);

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("rw_apb_engine: TIMEOUT_CYCLES must be >= 1");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] paddr_q;
   logic [DATA_W-1:0] pwdata_q;
   logic              pwrite_q;
   logic              psel_q;
   logic              penable_q;
   logic              done_q;
   logic              r_valid_q;
   logic              err_q;
   logic [DATA_W-1:0] r_data_q;

`ifdef RW_APB_TIMEOUT_EN
   // At least 8 bits wide. It grows only when TIMEOUT_CYCLES needs more.
   localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   // The counter value in the last allowed wait cycle. One more low cycle
   // makes the count reach TIMEOUT_CYCLES.
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   logic [CNT_W-1:0] wait_cnt_q;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pwrite_q  <= 1'b0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         done_q    <= 1'b0;
         r_valid_q <= 1'b0;
         err_q     <= 1'b0;
         r_data_q  <= '0;
`ifdef RW_APB_TIMEOUT_EN
         wait_cnt_q <= '0;
`endif
      end else begin
         // The response flags are single-cycle pulses. They are raised only
         // on the ACCESS -> RESP edge, so err is low whenever done is low.
         done_q    <= 1'b0;
         r_valid_q <= 1'b0;
         err_q     <= 1'b0;

         unique case (state_q)
            IDLE: begin
               // A write wins if both grants are seen at once.
               if (bus.w_grant) begin
                  paddr_q  <= bus.w_addr;
                  pwdata_q <= bus.w_data;
                  pwrite_q <= 1'b1;
                  psel_q   <= 1'b1;
                  state_q  <= SETUP;
               end else if (bus.r_grant) begin
                  paddr_q  <= bus.r_addr;
                  pwrite_q <= 1'b0;
                  psel_q   <= 1'b1;
                  state_q  <= SETUP;
               end
            end

            SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ACCESS;
`ifdef RW_APB_TIMEOUT_EN
               wait_cnt_q <= '0;
`endif
            end

            ACCESS: begin
               if (bus.pready) begin
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  done_q    <= 1'b1;
                  r_valid_q <= ~pwrite_q;
                  err_q     <= bus.pslverr;
                  if (!pwrite_q) begin
                     r_data_q <= bus.prdata;
                  end
                  state_q   <= RESP;
               end
`ifdef RW_APB_TIMEOUT_EN
               else if (wait_cnt_q == WAIT_LAST) begin
                  // Abandon the transfer. r_data keeps its previous value.
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  done_q    <= 1'b1;
                  r_valid_q <= ~pwrite_q;
                  err_q     <= 1'b1;
                  state_q   <= RESP;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
               end
`endif
            end

            RESP: begin
               // Grants are ignored here. The arbiter updates on this done
               // edge, so any grant seen next in IDLE is a new transaction.
               state_q <= IDLE;
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.paddr   = paddr_q;
   assign bus.pwdata  = pwdata_q;
   assign bus.pwrite  = pwrite_q;
   assign bus.psel    = psel_q;
   assign bus.penable = penable_q;
   assign bus.done    = done_q;
   assign bus.r_valid = r_valid_q;
   assign bus.err     = err_q;
   assign bus.r_data  = r_data_q;

endmodule

// File: tb/tb_rw_apb_engine.sv
// ---------------------------------------------------------------------------
// tb_rw_apb_engine
// Directed test of rw_apb_engine. The stimulus process plays the arbiter: it
// drives grants and queues the expected response of every transfer. A
// behavioural APB slave inserts the requested number of wait states. A
// monitor pops one expectation per done pulse and compares it.
// ---------------------------------------------------------------------------
module tb_rw_apb_engine;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int TMO    = 4;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   rw_apb_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   rw_apb_engine #(
      .ADDR_W         (ADDR_W),
      .DATA_W         (DATA_W),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      bit          rd;
      bit          err;
      logic [31:0] rdata;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   int          n_assert  = 0;
   int          n_fail    = 0;
   int          cyc       = 0;
   int          done_cnt  = 0;
   logic [31:0] model_rdata = '0;

   // slave configuration for the transfer in flight
   int          cfg_wait   = 0;     // pready-low cycles before ready; -1 = never
   logic [31:0] cfg_prdata = '0;
   bit          cfg_serr   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_assert++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_psel"},    bus.psel,    0);
      chk({tag, "_penable"}, bus.penable, 0);
      chk({tag, "_pwrite"},  bus.pwrite,  0);
      chk({tag, "_done"},    bus.done,    0);
      chk({tag, "_r_valid"}, bus.r_valid, 0);
      chk({tag, "_err"},     bus.err,     0);
      chk({tag, "_r_data"},  bus.r_data,  0);
      chk({tag, "_paddr"},   bus.paddr,   0);
      chk({tag, "_pwdata"},  bus.pwdata,  0);
   endtask

   // cycle index: increments at every rising edge
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // APB slave: pready rises after cfg_wait low ACCESS cycles
   initial begin
      int acc_cnt;
      acc_cnt     = 0;
      bus.pready  = 1'b0;
      bus.prdata  = '0;
      bus.pslverr = 1'b0;
      forever begin
         @(negedge clk);
         bus.prdata  = cfg_prdata;
         bus.pslverr = cfg_serr;
         if (bus.psel && bus.penable) begin
            bus.pready = (cfg_wait >= 0) && (acc_cnt == cfg_wait);
            acc_cnt++;
         end else begin
            acc_cnt    = 0;
            bus.pready = 1'b0;
         end
      end
   end

   // monitor / scoreboard
   initial begin
      bit   prev_done;
      exp_t e;
      prev_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            prev_done = 1'b0;
         end else begin
            if (bus.done) begin
               done_cnt++;
               chk("done_back_to_back", prev_done, 0);
               if (exp_q.size() == 0) begin
                  n_assert++;
                  n_fail++;
                  $display("FAIL unexpected_done: got done=1, expected no transfer pending (cycle %0d)", cyc);
               end else begin
                  e = exp_q.pop_front();
                  chk("resp_r_valid", bus.r_valid, e.rd);
                  chk("resp_err",     bus.err,     e.err);
                  chk("resp_r_data",  bus.r_data,  e.rdata);
                  chk("resp_cycle",   cyc,         e.cyc);
               end
            end else begin
               chk("err_without_done",     bus.err,     0);
               chk("r_valid_without_done", bus.r_valid, 0);
            end
            prev_done = bus.done;
         end
      end
   end

   // One granted transfer. Call at a falling edge. b2b=1 means the engine is
   // in RESP now, so its IDLE cycle comes one cycle later.
   task automatic issue(input bit wr, input bit both, input logic [31:0] addr,
                        input logic [31:0] data, input int waits, input bit serr,
                        input bit tmo, input bit drop, input bit b2b);
      int   n;
      int   k;
      exp_t e;
      n = b2b ? cyc + 1 : cyc;
      if (wr) begin
         bus.w_addr  = addr;
         bus.w_data  = data;
         bus.w_grant = 1'b1;
         bus.r_grant = both;
      end else begin
         bus.r_addr  = addr;
         bus.w_grant = 1'b0;
         bus.r_grant = 1'b1;
      end
      cfg_wait   = tmo ? -1 : waits;
      cfg_prdata = wr ? 32'h0 : data;
      cfg_serr   = serr;
      if (!wr && !tmo) model_rdata = data;
      e.rd    = !wr;
      e.err   = serr | tmo;
      e.rdata = model_rdata;
      e.cyc   = tmo ? n + 2 + TMO : n + 3 + waits;
      exp_q.push_back(e);

      while (cyc < n + 1) @(negedge clk);
      chk("setup_psel",    bus.psel,    1);
      chk("setup_penable", bus.penable, 0);
      chk("setup_paddr",   bus.paddr,   addr);
      chk("setup_pwrite",  bus.pwrite,  wr);
      @(negedge clk);
      chk("access_psel",    bus.psel,    1);
      chk("access_penable", bus.penable, 1);
      chk("access_paddr",   bus.paddr,   addr);
      chk("access_pwrite",  bus.pwrite,  wr);
      if (wr) chk("access_pwdata", bus.pwdata, data);
      if (drop) begin
         bus.w_grant = 1'b0;
         bus.r_grant = 1'b0;
      end

      k = 0;
      while (!bus.done && k < 64) begin
         @(negedge clk);
         k++;
      end
      if (!bus.done) begin
         n_assert++;
         n_fail++;
         $display("FAIL done_wait: got no done within 64 cycles, expected done at cycle %0d", e.cyc);
      end
      // arbiter advances on done
      bus.w_grant = 1'b0;
      bus.r_grant = 1'b0;
   endtask

   initial begin
      int n;
      int d0;
      bus.w_grant = 1'b0;
      bus.r_grant = 1'b0;
      bus.w_addr  = '0;
      bus.w_data  = '0;
      bus.r_addr  = '0;

      // reset state
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check_idle("in_reset");
      reset_n = 1'b1;
      @(negedge clk);
      check_idle("post_reset");

      // zero-wait write
      issue(1, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      @(negedge clk);
      // wait-state read
      issue(0, 0, 32'h24, 32'h12345678, 3, 0, 0, 0, 0);
      @(negedge clk);
      // simultaneous grants: the write goes first, then the read back-to-back
      bus.r_addr = 32'h34;
      issue(1, 1, 32'h30, 32'hA5A5A5A5, 0, 0, 0, 0, 0);
      issue(0, 0, 32'h34, 32'h0BADF00D, 1, 0, 0, 0, 1);
      @(negedge clk);
      // slave error on a read
      issue(0, 0, 32'h40, 32'h55AA55AA, 0, 1, 0, 0, 0);
      @(negedge clk);
      // write with waits, grant dropped mid-transfer; r_data must hold
      issue(1, 0, 32'h44, 32'h01234567, 2, 0, 0, 1, 0);
      @(negedge clk);
`ifdef RW_APB_TIMEOUT_EN
      // timeout: pready never rises
      issue(0, 0, 32'h48, 32'hFFFF0000, 0, 0, 1, 0, 0);
      @(negedge clk);
`endif

      // read stuck in ACCESS, then reset in mid-transfer
      n          = cyc;
      cfg_wait   = -1;
      cfg_prdata = 32'h77777777;
      cfg_serr   = 1'b0;
      bus.r_addr = 32'h60;
      bus.r_grant = 1'b1;
      while (cyc < n + 2) @(negedge clk);
      chk("stuck_access_psel",    bus.psel,    1);
      chk("stuck_access_penable", bus.penable, 1);
      d0 = done_cnt;
`ifndef RW_APB_TIMEOUT_EN
      repeat (20) @(negedge clk);
      chk("no_done_without_timeout", done_cnt, d0);
      chk("still_in_access",         bus.penable, 1);
`endif
      #1 reset_n = 1'b0;
      #1;
      chk("async_reset_psel",    bus.psel,    0);
      chk("async_reset_penable", bus.penable, 0);
      chk("async_reset_done",    bus.done,    0);
      bus.r_grant = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      model_rdata = '0;
      @(negedge clk);
      check_idle("after_mid_reset");
      chk("no_done_for_aborted", done_cnt, d0);

      // recovery after reset
      issue(0, 0, 32'h64, 32'h89ABCDEF, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation time limit, expected end of test");
      $fatal(1, "watchdog expired");
   end

endmodule
